// File: rtl/hmr_pkg.sv
// hmr_pkg: shared types and constants for host_mem_responder
package hmr_pkg;
  localparam int PKG_DATA_W = 32;
  localparam logic [20:0] FLAG_ADDR_DEF = 21'h1F_FFFF;
  localparam logic [31:0] BAD_DATA_DEF = 32'hDEAD_BEEF;
  typedef enum logic {SRC_FPGA = 1'b0, SRC_PCI = 1'b1} access_src_e;
  typedef enum logic {P_IDLE = 1'b0, P_WAIT = 1'b1} host_state_e;
  typedef struct packed {
    logic valid;
    access_src_e src;
    logic [PKG_DATA_W-1:0] data;
  } rd_pipe_entry_t;
endpackage

// File: rtl/host_mem_responder_if.sv
// host_mem_responder_if: host (PCI) request/response, FPGA read/write and flag channel bundle
//   master: drives requests, write data and status updates; slave: returns busy, read data, flags
interface host_mem_responder_if #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] pci_req_addr;
  logic [DATA_W-1:0] pci_input_data;
  logic pci_wr_en;
  logic pci_rd_en;
  logic pci_busy;
  logic [DATA_W-1:0] pci_rd_data;
  logic pci_rd_valid;
  logic rd_req;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] rd_data;
  logic rd_ready;
  logic FPGA_wr_en;
  logic [DATA_W-1:0] write_data;
  logic flag_we;
  logic [DATA_W-1:0] out_flag;
  logic [DATA_W-1:0] in_flag;
  logic host_flag_new;
  logic proto_err;
  modport master (
    output pci_req_addr, pci_input_data, pci_wr_en, pci_rd_en, rd_req, req_addr,
           FPGA_wr_en, write_data, flag_we, out_flag,
    input  pci_busy, pci_rd_data, pci_rd_valid, rd_data, rd_ready, in_flag,
           host_flag_new, proto_err
  );
  modport slave (
    input  pci_req_addr, pci_input_data, pci_wr_en, pci_rd_en, rd_req, req_addr,
           FPGA_wr_en, write_data, flag_we, out_flag,
    output pci_busy, pci_rd_data, pci_rd_valid, rd_data, rd_ready, in_flag,
           host_flag_new, proto_err
  );
endinterface

// File: rtl/hmr_ram.sv
// hmr_ram: single-port synchronous word RAM, write-first, 1-cycle read
//   clk; en/we access strobes; addr word index; wdata write word; rdata registered read word
module hmr_ram #(
  parameter int DEPTH = 2**18,
  parameter int DATA_W = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic en,
  input  logic we,
  input  logic [AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata_q <= we ? wdata : mem[addr];
    end
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/host_mem_responder.sv
// host_mem_responder: shared-memory responder serving host (PCI) and FPGA sides from one word RAM
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of host_mem_responder_if (host requests, FPGA read/write, flag channel)
module host_mem_responder
  import hmr_pkg::*;
#(
  parameter int ADDR_W = 21,
  parameter int DATA_W = PKG_DATA_W,
  parameter int DEPTH = 2**18,
  parameter int RD_LAT = 1,
  parameter logic [ADDR_W-1:0] FLAG_ADDR = FLAG_ADDR_DEF,
  parameter logic [DATA_W-1:0] BAD_DATA = BAD_DATA_DEF
) (
  input logic clk,
  input logic rst,
  host_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  host_state_e state_q, state_d;
  logic fpga_any, host_any, pci_wr_go, pci_rd_go, fpga_rd_go;
  logic acc_rd, acc_wr, acc_ram, acc_flag;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata, ram_rdata, in_flag_q, status_q, rd_hold_q, pci_hold_q;
  logic flag_new_q, proto_err_q, ram_sel_q, fpga_hit, pci_hit;
  rd_pipe_entry_t meta_d, meta_q, head, tail;
  assign fpga_any = bus.FPGA_wr_en | bus.rd_req;
  assign host_any = bus.pci_wr_en | bus.pci_rd_en;
  assign fpga_rd_go = bus.rd_req & ~bus.FPGA_wr_en;
  // a host read also stalls while its own write takes the slot
  assign bus.pci_busy = (fpga_any & host_any) | (bus.pci_wr_en & bus.pci_rd_en);
  always_comb begin
    pci_wr_go = bus.pci_wr_en & ~fpga_any;
    pci_rd_go = bus.pci_rd_en & ~bus.pci_wr_en & ~fpga_any;
    state_d = (state_q == P_IDLE) ? ((host_any & fpga_any) ? P_WAIT : P_IDLE)
                                  : ((~host_any | ~fpga_any) ? P_IDLE : P_WAIT);
  end
  assign acc_addr = fpga_any ? bus.req_addr : bus.pci_req_addr;
  assign acc_ram = {1'b0, acc_addr} < DEPTH_A;
  assign acc_flag = acc_addr == FLAG_ADDR;
  assign acc_rd = fpga_rd_go | pci_rd_go;
  assign acc_wr = bus.FPGA_wr_en | pci_wr_go;
  assign acc_wdata = bus.FPGA_wr_en ? bus.write_data : bus.pci_input_data;
  hmr_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ram (
    .clk(clk),
    .en(acc_ram & (acc_rd | acc_wr)),
    .we(acc_wr),
    .addr(acc_addr[AW-1:0]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );
  // non-RAM read data is captured at acceptance and merged with the RAM output one cycle later
  always_comb begin
    meta_d.valid = acc_rd;
    meta_d.src = fpga_rd_go ? SRC_FPGA : SRC_PCI;
    meta_d.data = ~acc_flag ? BAD_DATA : (fpga_rd_go ? in_flag_q : status_q);
    head = meta_q;
    head.data = ram_sel_q ? ram_rdata : meta_q.data;
  end
  if (RD_LAT == 1) begin : g_lat1
    assign tail = head;
  end else begin : g_latn
    rd_pipe_entry_t dl_q [RD_LAT-1];
    always_ff @(posedge clk) begin
      dl_q[0] <= rst ? '0 : head;
      for (int i = 1; i < RD_LAT-1; i++) dl_q[i] <= rst ? '0 : dl_q[i-1];
    end
    assign tail = dl_q[RD_LAT-2];
  end
  assign fpga_hit = tail.valid & (tail.src == SRC_FPGA);
  assign pci_hit = tail.valid & (tail.src == SRC_PCI);
  assign bus.rd_ready = fpga_hit;
  assign bus.rd_data = fpga_hit ? tail.data : rd_hold_q;
  assign bus.pci_rd_valid = pci_hit;
  assign bus.pci_rd_data = pci_hit ? tail.data : pci_hold_q;
  assign bus.in_flag = in_flag_q;
  assign bus.host_flag_new = flag_new_q;
  assign bus.proto_err = proto_err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= P_IDLE;
      meta_q <= '0;
      ram_sel_q <= 1'b0;
      rd_hold_q <= '0;
      pci_hold_q <= '0;
      in_flag_q <= '0;
      status_q <= '0;
      flag_new_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      meta_q <= meta_d;
      ram_sel_q <= acc_ram;
      rd_hold_q <= bus.rd_data;
      pci_hold_q <= bus.pci_rd_data;
      in_flag_q <= (pci_wr_go & acc_flag) ? bus.pci_input_data : '0;
      status_q <= bus.flag_we ? bus.out_flag : status_q;
      flag_new_q <= bus.flag_we | (flag_new_q & ~(pci_rd_go & acc_flag));
      proto_err_q <= proto_err_q | (bus.FPGA_wr_en & bus.rd_req);
    end
  end
endmodule

// File: tb/tb_host_mem_responder.sv
// tb_host_mem_responder: directed and random checks of host_mem_responder at RD_LAT 1 and 3
module tb_host_mem_responder;
  localparam logic [20:0] FLAG = 21'h1F_FFFF;
  localparam logic [20:0] DEP = 21'h04_0000;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  typedef struct {int due; int lat; bit pci; logic [31:0] d;} ev_t;
  logic clk = 1'b0;
  logic rst;
  int n_chk, n_fail, cyc;
  ev_t evq[$];
  logic [31:0] mem [int];
  logic [31:0] m_status, m_inflag;
  logic [31:0] hf [2];
  logic [31:0] hp [2];
  bit m_new, m_err;
  always #5 clk = ~clk;
  host_mem_responder_if b1 ();
  host_mem_responder_if b3 ();
  assign b3.pci_req_addr = b1.pci_req_addr;
  assign b3.pci_input_data = b1.pci_input_data;
  assign b3.pci_wr_en = b1.pci_wr_en;
  assign b3.pci_rd_en = b1.pci_rd_en;
  assign b3.rd_req = b1.rd_req;
  assign b3.req_addr = b1.req_addr;
  assign b3.FPGA_wr_en = b1.FPGA_wr_en;
  assign b3.write_data = b1.write_data;
  assign b3.flag_we = b1.flag_we;
  assign b3.out_flag = b1.out_flag;
  host_mem_responder #(.RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  host_mem_responder #(.RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    b1.pci_wr_en = 1'b0;
    b1.pci_rd_en = 1'b0;
    b1.rd_req = 1'b0;
    b1.FPGA_wr_en = 1'b0;
    b1.flag_we = 1'b0;
  endtask
  function automatic logic [31:0] rd_val(logic [20:0] a, logic fpga);
    if (a < DEP) return mem[int'(a)];
    if (a == FLAG) return fpga ? m_inflag : m_status;
    return BAD;
  endfunction
  function automatic logic [20:0] pick();
    case ($urandom_range(0, 9))
      0: return FLAG;
      1: return 21'h10_0000;
      2: return DEP;
      3: return DEP - 21'd1;
      default: return 21'($urandom_range(1, 64));
    endcase
  endfunction
  task automatic chk_out(int k, logic rdy, logic [31:0] rd, logic pv, logic [31:0] pd,
                         logic [31:0] inf, logic nw, logic er);
    bit fv, pe;
    string s;
    fv = 0;
    pe = 0;
    s = (k != 0) ? "L3" : "L1";
    foreach (evq[i]) if (evq[i].due == cyc && evq[i].lat == k) begin
      if (evq[i].pci) begin pe = 1; hp[k] = evq[i].d; end
      else begin fv = 1; hf[k] = evq[i].d; end
    end
    chk({s, " rd_ready"}, 32'(rdy), 32'(fv));
    chk({s, " rd_data"}, rd, hf[k]);
    chk({s, " pci_rd_valid"}, 32'(pv), 32'(pe));
    chk({s, " pci_rd_data"}, pd, hp[k]);
    chk({s, " in_flag"}, inf, m_inflag);
    chk({s, " host_flag_new"}, 32'(nw), 32'(m_new));
    chk({s, " proto_err"}, 32'(er), 32'(m_err));
  endtask
  task automatic step();
    logic fa, fw, fr, pw, pr;
    logic [20:0] a;
    logic [31:0] d;
    #1;
    fw = b1.FPGA_wr_en;
    fr = b1.rd_req;
    pw = b1.pci_wr_en;
    pr = b1.pci_rd_en;
    fa = fw | fr;
    a = fa ? b1.req_addr : b1.pci_req_addr;
    chk("L1 pci_busy", 32'(b1.pci_busy), 32'((fa & (pw | pr)) | (pw & pr)));
    chk("L3 pci_busy", 32'(b3.pci_busy), 32'((fa & (pw | pr)) | (pw & pr)));
    if (rst) begin
      evq.delete();
      m_status = '0;
      m_inflag = '0;
      m_new = 0;
      m_err = 0;
      hf[0] = '0; hf[1] = '0; hp[0] = '0; hp[1] = '0;
    end else begin
      if ((fr & !fw) | (pr & !pw & !fa)) begin
        d = rd_val(a, fa);
        evq.push_back('{due: cyc + 1, lat: 0, pci: !fa, d: d});
        evq.push_back('{due: cyc + 3, lat: 1, pci: !fa, d: d});
      end
      if (fw && a < DEP) mem[int'(a)] = b1.write_data;
      if (pw && !fa && a < DEP) mem[int'(a)] = b1.pci_input_data;
      m_inflag = (pw && !fa && a == FLAG) ? b1.pci_input_data : 32'h0;
      if (b1.flag_we) begin
        m_status = b1.out_flag;
        m_new = 1;
      end else if (pr && !pw && !fa && a == FLAG) m_new = 0;
      m_err = m_err | (fw & fr);
    end
    @(posedge clk);
    cyc++;
    #1;
    chk_out(0, b1.rd_ready, b1.rd_data, b1.pci_rd_valid, b1.pci_rd_data, b1.in_flag, b1.host_flag_new, b1.proto_err);
    chk_out(1, b3.rd_ready, b3.rd_data, b3.pci_rd_valid, b3.pci_rd_data, b3.in_flag, b3.host_flag_new, b3.proto_err);
    for (int i = evq.size() - 1; i >= 0; i--) if (evq[i].due <= cyc) evq.delete(i);
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    rst = 1'b1;
    idle();
    b1.pci_req_addr = '0;
    b1.req_addr = '0;
    b1.pci_input_data = '0;
    b1.write_data = '0;
    b1.out_flag = '0;
    repeat (2) step();
    chk("reset rd_data", b1.rd_data, 32'h0);
    chk("reset in_flag", b3.in_flag, 32'h0);
    rst = 1'b0;
    b1.pci_wr_en = 1'b1;
    b1.pci_input_data = 32'h4143_4143;
    for (int a = 1; a <= 64; a++) begin
      b1.pci_req_addr = 21'(a);
      step();
    end
    b1.pci_req_addr = DEP - 21'd1;
    b1.pci_input_data = 32'h0BAD_F00D;
    step();
    b1.pci_req_addr = DEP;
    b1.pci_input_data = 32'h1234_5678;
    step();
    idle();
    b1.rd_req = 1'b1;
    b1.req_addr = 21'd37;
    step();
    chk("preload rd_ready", 32'(b1.rd_ready), 32'h1);
    chk("preload rd_data", b1.rd_data, 32'h4143_4143);
    b1.req_addr = DEP - 21'd1;
    step();
    chk("top word", b1.rd_data, 32'h0BAD_F00D);
    b1.req_addr = DEP;
    step();
    chk("depth unmapped", b1.rd_data, BAD);
    b1.pci_wr_en = 1'b1;
    b1.pci_req_addr = 21'd5;
    b1.pci_input_data = 32'h5555_0005;
    for (int i = 0; i < 3; i++) begin
      b1.req_addr = 21'(10 + i);
      step();
    end
    b1.rd_req = 1'b0;
    step();
    b1.pci_wr_en = 1'b0;
    b1.pci_rd_en = 1'b1;
    step();
    chk("contention write", b1.pci_rd_data, 32'h5555_0005);
    idle();
    b1.pci_wr_en = 1'b1;
    b1.pci_req_addr = FLAG;
    b1.pci_input_data = 32'h0001_0000;
    step();
    chk("command pulse", b1.in_flag, 32'h0001_0000);
    b1.pci_wr_en = 1'b0;
    b1.rd_req = 1'b1;
    b1.req_addr = FLAG;
    step();
    chk("command clear", b1.in_flag, 32'h0);
    chk("fpga flag read", b1.rd_data, 32'h0001_0000);
    idle();
    b1.flag_we = 1'b1;
    b1.out_flag = 32'h42;
    step();
    chk("status new", 32'(b1.host_flag_new), 32'h1);
    b1.flag_we = 1'b0;
    b1.pci_rd_en = 1'b1;
    b1.pci_req_addr = FLAG;
    step();
    chk("status read", b1.pci_rd_data, 32'h42);
    chk("status cleared", 32'(b1.host_flag_new), 32'h0);
    b1.pci_rd_en = 1'b0;
    b1.flag_we = 1'b1;
    b1.out_flag = 32'h55;
    step();
    b1.out_flag = 32'h77;
    b1.pci_rd_en = 1'b1;
    step();
    chk("status old value", b1.pci_rd_data, 32'h55);
    chk("status set wins", 32'(b1.host_flag_new), 32'h1);
    b1.flag_we = 1'b0;
    step();
    chk("status latched", b1.pci_rd_data, 32'h77);
    idle();
    b1.rd_req = 1'b1;
    b1.req_addr = 21'h10_0000;
    step();
    chk("bad data", b1.rd_data, BAD);
    b1.FPGA_wr_en = 1'b1;
    b1.req_addr = 21'd7;
    b1.write_data = 32'hCAFE_0007;
    step();
    chk("collide no ready", 32'(b1.rd_ready), 32'h0);
    chk("collide proto_err", 32'(b1.proto_err), 32'h1);
    b1.FPGA_wr_en = 1'b0;
    step();
    chk("collide write", b1.rd_data, 32'hCAFE_0007);
    b1.rd_req = 1'b0;
    b1.FPGA_wr_en = 1'b1;
    b1.req_addr = 21'd9;
    b1.write_data = 32'h9999_0009;
    step();
    b1.FPGA_wr_en = 1'b0;
    b1.rd_req = 1'b1;
    step();
    chk("write first", b1.rd_data, 32'h9999_0009);
    for (int i = 0; i < 400; i++) begin
      b1.FPGA_wr_en = ($urandom_range(0, 9) == 0);
      b1.rd_req = ($urandom_range(0, 2) == 0);
      b1.pci_wr_en = ($urandom_range(0, 3) == 0);
      b1.pci_rd_en = ($urandom_range(0, 3) == 0);
      b1.flag_we = ($urandom_range(0, 7) == 0);
      b1.req_addr = pick();
      b1.pci_req_addr = pick();
      b1.write_data = $urandom();
      b1.pci_input_data = $urandom();
      b1.out_flag = $urandom();
      step();
    end
    idle();
    repeat (3) step();
    b1.rd_req = 1'b1;
    b1.req_addr = 21'd37;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post-reset rd_data", b3.rd_data, 32'h0);
    chk("post-reset pci_rd_data", b3.pci_rd_data, 32'h0);
    chk("post-reset flags", {29'h0, b3.in_flag != 0, b3.host_flag_new, b3.proto_err}, 32'h0);
    chk("post-reset L1 rd_data", b1.rd_data, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("dropped read", 32'(b3.rd_ready), 32'h0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/host_mem_responder.md
Name: host_mem_responder

Overview:
- Host-side shared-memory responder at the far end of the user_interface memory/flag protocol.
- Host (PCI) side preloads template/window words, reads back results and polls the flag register.
- FPGA side is served with fixed-latency reads, writes and a flag channel.
- Single-port word RAM with arbitration (FPGA side has priority); memory-mapped flag/status registers.

Parameters:
- ADDR_W, 21, width of pci_req_addr / req_addr.
- DATA_W, 32, word width.
- DEPTH, 2**18, RAM words; valid RAM addresses 0..DEPTH-1.
- RD_LAT, 1, cycles from accepted read to data valid (1..4).
- FLAG_ADDR, 21'h1F_FFFF, address of the flag register.
- BAD_DATA, 32'hDEAD_BEEF, data returned for unmapped reads.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pci_req_addr  in  ADDR_W  host address.
- pci_input_data  in  DATA_W  host write data.
- pci_wr_en  in  1  host write request, held until accepted.
- pci_rd_en  in  1  host read request, held until accepted.
- pci_busy  out  1  combinational; host request not accepted this cycle.
- pci_rd_data  out  DATA_W  host read data.
- pci_rd_valid  out  1  pulse, pci_rd_data valid.
- rd_req  in  1  FPGA read request (never stalled).
- req_addr  in  ADDR_W  FPGA address for reads and writes.
- rd_data  out  DATA_W  FPGA read data.
- rd_ready  out  1  pulse, rd_data valid.
- FPGA_wr_en  in  1  FPGA write of write_data to req_addr.
- write_data  in  DATA_W  FPGA write data.
- flag_we  in  1  FPGA status update strobe.
- out_flag  in  DATA_W  FPGA status word.
- in_flag  out  DATA_W  command word to FPGA.
- host_flag_new  out  1  sticky; unread status present.
- proto_err  out  1  sticky; FPGA_wr_en and rd_req asserted together.

Behaviour:
- Reset: every output 0; pipeline emptied; status register 0; RAM contents not cleared.
- Reset asserted mid-operation drops every in-flight read; no valid pulse is issued for it afterwards.
- Arbitration, one RAM access per cycle; priority order: FPGA_wr_en, then rd_req, then pci_wr_en, then pci_rd_en.
  - pci_busy = (FPGA_wr_en | rd_req) & (pci_wr_en | pci_rd_en).
  - pci_busy is also asserted for pci_rd_en when pci_wr_en wins the slot.
  - The host holds its request while pci_busy is high.
- FPGA_wr_en and rd_req in the same cycle: the write is performed, the read is dropped (no rd_ready), proto_err sets.
- Read pipeline: shift register RD_LAT deep; each entry is {valid, src (0 = FPGA, 1 = PCI), data}.
  - Accepted read at cycle N: data and valid pulse appear at cycle N+RD_LAT.
  - rd_data / pci_rd_data hold their last value when no valid pulse is issued.
- Address decode, identical for both sides:
  - addr < DEPTH: RAM.
  - addr == FLAG_ADDR: flag register.
  - Anything else: writes ignored; reads return BAD_DATA with normal latency.
- FPGA read to the same address as a write accepted on the previous cycle returns the new data (write-first).
- Flag register:
  - PCI write to FLAG_ADDR: in_flag = data for exactly one cycle (registered), then 0.
  - Back-to-back host writes produce back-to-back command cycles.
  - flag_we: status register <= out_flag; host_flag_new sets.
  - PCI read of FLAG_ADDR returns the status register and clears host_flag_new at acceptance.
  - flag_we in the same cycle as that accepted read: the read returns the old value, the new value is latched, host_flag_new stays set (set wins).
  - FPGA read of FLAG_ADDR returns the current in_flag value.
- Host FSM:
  - P_IDLE: request seen and no grant → P_WAIT; request seen and granted → issue, stay in P_IDLE.
  - P_WAIT: on grant → issue, return to P_IDLE.
  - Request deasserted while in P_WAIT → P_IDLE, nothing issued.
- Width rules: RAM index = addr[$clog2(DEPTH)-1:0] after the range check; no truncation aliasing.

Decomposition:
- Package hmr_pkg:
  - typedef access_src_e {SRC_FPGA, SRC_PCI}.
  - typedef rd_pipe_entry_t {valid, src, data}.
  - typedef host_state_e {P_IDLE, P_WAIT}.
  - Constants FLAG_ADDR_DEF and BAD_DATA_DEF.
- One sub-module, hmr_ram: single-port synchronous RAM with DEPTH and DATA_W, write-first, 1-cycle read.
- Extra RD_LAT-1 stages live in the parent.

Test Plan:
- Host preloads: PCI writes 32'h41434143 to addresses 1..64, no FPGA traffic → pci_busy stays 0 throughout; FPGA rd_req at address 37 → rd_ready pulse one cycle later with rd_data = 32'h41434143.
- Contention: pci_wr_en to address 5 held while FPGA rd_req runs for 3 cycles → pci_busy high 3 cycles; the write lands on cycle 4; FPGA reads are unaffected.
- Start command: PCI write 32'h0001_0000 to FLAG_ADDR → in_flag = 32'h0001_0000 for exactly one cycle, then 0.
- Status path: flag_we with out_flag = 32'h0000_0042 → host_flag_new = 1; PCI read of FLAG_ADDR returns 32'h42 and clears it; repeat with flag_we in the same cycle as the read → old value returned, host_flag_new remains 1.
- Errors: rd_req at address 21'h10_0000 → rd_data = 32'hDEAD_BEEF; FPGA_wr_en and rd_req together → write performed, no rd_ready, proto_err = 1.
- Reset mid-read with RD_LAT = 3: rst asserted one cycle after rd_req → no rd_ready ever appears for it; all outputs 0 the cycle after rst.
